// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Shared types and width helpers for the multi-channel PWM.
//               Optional macro PWM_CENTER_ALIGNED_EN selects triangle counting.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Channel-select width; a single channel still gets a 1-bit select port.
    function automatic int ch_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    // Highest value the period counter reaches (2^N-2).
    function automatic int cnt_max(input int n);
        return (1 << n) - 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : pwm_prescaler
// Description : Divides clk into one step pulse every prescale+1 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  step
);

    logic [PRESCALE_W-1:0] r_pcnt;
    logic                  w_wrap;

    // ">=" lets a prescale shrunk below the running count wrap on the next cycle.
    assign w_wrap = (r_pcnt >= prescale);
    assign step   = ena & w_wrap;

    always_ff @(posedge clk) begin
        if (rst || !ena) begin
            r_pcnt <= '0;
        end else if (w_wrap) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_multi.sv
`default_nettype none
// ============================================================================
// Module      : pwm_multi
// Description : Multi-channel PWM with shared prescaler/period counter and
//               double-buffered per-channel duty. Macro PWM_CENTER_ALIGNED_EN
//               selects up/down (center-aligned) counting.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_multi
    import pwm_pkg::*;
#(
    parameter  int N          = 8,
    parameter  int CHANNELS   = 4,
    parameter  int PRESCALE_W = 16,
    localparam int c_ch_w     = ch_width(CHANNELS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [CHANNELS-1:0]   ch_ena,
    input  logic                  wr_en,
    input  logic [c_ch_w-1:0]     wr_ch,
    input  logic [N-1:0]          wr_duty,
    output logic [CHANNELS-1:0]   out,
    output logic                  period_start
);

    typedef logic [N-1:0] duty_t;

    localparam duty_t c_cnt_max = duty_t'(cnt_max(N));

    logic                w_step;
    logic                w_load;
    duty_t               r_cnt;
    duty_t               w_cnt_nxt;
    duty_t               r_shadow [CHANNELS];
    duty_t               r_active [CHANNELS];
    logic [CHANNELS-1:0] w_hit;

`ifdef PWM_CENTER_ALIGNED_EN
    localparam duty_t c_one = duty_t'(1);
    dir_e r_dir;
    dir_e w_dir_nxt;
`endif

    pwm_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .prescale (prescale),
        .step     (w_step)
    );

    // ------------------------------------------------------------------
    // Period counter next-state
    // ------------------------------------------------------------------
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_load    = 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
        w_dir_nxt = r_dir;
        if (!ena) begin
            w_cnt_nxt = '0;
            w_dir_nxt = DIR_UP;
        end else if (w_step) begin
            if (r_dir == DIR_UP) begin
                if (r_cnt == c_cnt_max) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                    w_dir_nxt = DIR_DOWN;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end else begin
                // Descending through 1 closes the triangle; 0 opens the next one.
                if (r_cnt == c_one) begin
                    w_cnt_nxt = '0;
                    w_dir_nxt = DIR_UP;
                    w_load    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
        end
`else
        if (!ena) begin
            w_cnt_nxt = '0;
        end else if (w_step) begin
            if (r_cnt == c_cnt_max) begin
                w_cnt_nxt = '0;
                w_load    = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            period_start <= 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
            r_dir        <= DIR_UP;
`endif
        end else begin
            r_cnt        <= w_cnt_nxt;
            period_start <= w_load;
`ifdef PWM_CENTER_ALIGNED_EN
            r_dir        <= w_dir_nxt;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Duty double buffer: the load reads the pre-write shadow, so a write
    // landing on the load edge takes effect one period later.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!ena || w_load) begin
                    r_active[i] <= r_shadow[i];
                end
                if (wr_en && (wr_ch == c_ch_w'(i))) begin
                    r_shadow[i] <= wr_duty;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Compare stage
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_cmp
        assign w_hit[gi] = ena & ch_ena[gi] & (r_cnt < r_active[gi]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out <= '0;
        end else begin
            out <= w_hit;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_multi
// Description : Self-checking bench for pwm_multi (N=4, CHANNELS=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_multi;

    localparam int N    = 4;
    localparam int CH   = 4;
    localparam int PW   = 16;
    localparam int MAXC = (1 << N) - 2;
`ifdef PWM_CENTER_ALIGNED_EN
    localparam int PER  = 2 * MAXC;
`else
    localparam int PER  = MAXC + 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ena = 1'b0;
    logic [PW-1:0] prescale = '0;
    logic [CH-1:0] ch_ena = '0;
    logic          wr_en = 1'b0;
    logic [1:0]    wr_ch = '0;
    logic [N-1:0]  wr_duty = '0;
    logic [CH-1:0] out;
    logic          period_start;

    int checks = 0;
    int errors = 0;

    // Reference model: position within the period plus the duty buffers.
    int       m_pcnt, m_phase;
    int       m_shadow [CH];
    int       m_active [CH];
    logic [CH-1:0] m_out;
    logic     m_ps;

    // Cycle bookkeeping for pulse-width measurements.
    int hi_cnt [CH];
    int ps_n, ps_first, kcyc;

    pwm_multi #(.N(N), .CHANNELS(CH), .PRESCALE_W(PW)) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .prescale     (prescale),
        .ch_ena       (ch_ena),
        .wr_en        (wr_en),
        .wr_ch        (wr_ch),
        .wr_duty      (wr_duty),
        .out          (out),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    function automatic int level_of(input int phase);
        return (phase <= MAXC) ? phase : (PER - phase);
    endfunction

    task automatic model_update();
        logic [CH-1:0] nout;
        if (rst) begin
            m_pcnt = 0; m_phase = 0; m_out = '0; m_ps = 1'b0;
            for (int i = 0; i < CH; i++) begin m_shadow[i] = 0; m_active[i] = 0; end
        end else begin
            for (int i = 0; i < CH; i++)
                nout[i] = ena && ch_ena[i] && (level_of(m_phase) < m_active[i]);
            m_ps = 1'b0;
            if (!ena) begin
                m_pcnt = 0; m_phase = 0;
                for (int i = 0; i < CH; i++) m_active[i] = m_shadow[i];
            end else if (m_pcnt >= int'(prescale)) begin
                m_pcnt  = 0;
                m_phase = (m_phase + 1) % PER;
                if (m_phase == 0) begin
                    for (int i = 0; i < CH; i++) m_active[i] = m_shadow[i];
                    m_ps = 1'b1;
                end
            end else begin
                m_pcnt++;
            end
            if (wr_en) m_shadow[wr_ch] = int'(wr_duty);
            m_out = nout;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        kcyc++;
        for (int i = 0; i < CH; i++) hi_cnt[i] += int'(out[i]);
        if (period_start === 1'b1) begin
            ps_n++;
            if (ps_first == 0) ps_first = kcyc;
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < CH; i++) hi_cnt[i] = 0;
        ps_n = 0; ps_first = 0; kcyc = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_write(input int ch, input int d);
        wr_en = 1'b1; wr_ch = 2'(ch); wr_duty = N'(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_ps(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            tick();
            if (period_start === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        run(3);
        checks++; if (out !== 4'h0) begin errors++; $display("FAIL reset_out got %h want 0", out); end
        checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL reset_ps got %b want 0", period_start); end
        rst = 1'b0;
    endtask

    task automatic test_duty_basic();
        bit ok;
        int d3;
        d3 = $urandom_range(1, 14);
        prescale = 0; ch_ena = 4'hF; ena = 1'b1;
        do_write(0, 5); do_write(1, 0); do_write(2, 15); do_write(3, d3);
        wait_ps(40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_ps_timeout got 0 want 1"); end
        for (int p = 0; p < 2; p++) begin
            clear_counts(); run(PER);
            checks++; if (hi_cnt[0] != 5) begin errors++; $display("FAIL basic_ch0_high got %0d want 5", hi_cnt[0]); end
            checks++; if (hi_cnt[1] != 0) begin errors++; $display("FAIL basic_ch1_zero got %0d want 0", hi_cnt[1]); end
            checks++; if (hi_cnt[2] != PER) begin errors++; $display("FAIL basic_ch2_full got %0d want %0d", hi_cnt[2], PER); end
            checks++; if (hi_cnt[3] != d3) begin errors++; $display("FAIL basic_ch3_rand got %0d want %0d", hi_cnt[3], d3); end
            checks++; if (ps_n != 1 || ps_first != PER) begin
                errors++; $display("FAIL basic_period got n=%0d at=%0d want n=1 at=%0d", ps_n, ps_first, PER); end
        end
    endtask

    task automatic test_prescale_write();
        bit ok;
        int want [4];
        want = '{9, 27, 27, 6};
        prescale = 2;
        do_write(0, 3);
        wait_ps(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL presc_ps_timeout got 0 want 1"); end
        for (int p = 0; p < 4; p++) begin
            clear_counts();
            if (p == 0) begin
                run(10); do_write(0, 9); run(3 * PER - 11);
            end else if (p == 1) begin
                run(3 * PER - 1); do_write(0, 2);
            end else begin
                run(3 * PER);
            end
            checks++; if (hi_cnt[0] != want[p]) begin
                errors++; $display("FAIL presc_high_p%0d got %0d want %0d", p, hi_cnt[0], want[p]); end
            checks++; if (ps_n != 1 || ps_first != 3 * PER) begin
                errors++; $display("FAIL presc_period_p%0d got n=%0d at=%0d want n=1 at=%0d", p, ps_n, ps_first, 3 * PER); end
        end
        prescale = 0;
    endtask

    task automatic test_enable();
        int sum;
        ena = 1'b0; ch_ena = 4'b0111;
        clear_counts();
        run(5); do_write(0, 7); run(5); do_write(1, 15); run(3); do_write(3, 10); run(5);
        sum = hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3];
        checks++; if (sum != 0) begin errors++; $display("FAIL ena_low_out got %0d highs want 0", sum); end
        checks++; if (ps_n != 0) begin errors++; $display("FAIL ena_low_ps got %0d want 0", ps_n); end
        ena = 1'b1;
        clear_counts(); run(PER);
        checks++; if (hi_cnt[0] != 7) begin errors++; $display("FAIL ena_ch0 got %0d want 7", hi_cnt[0]); end
        checks++; if (hi_cnt[1] != PER) begin errors++; $display("FAIL ena_ch1 got %0d want %0d", hi_cnt[1], PER); end
        checks++; if (hi_cnt[2] != PER) begin errors++; $display("FAIL ena_ch2 got %0d want %0d", hi_cnt[2], PER); end
        checks++; if (hi_cnt[3] != 0) begin errors++; $display("FAIL ena_ch3_gated got %0d want 0", hi_cnt[3]); end
        checks++; if (ps_first != PER) begin errors++; $display("FAIL ena_first_ps got %0d want %0d", ps_first, PER); end
        ch_ena = 4'hF;
    endtask

    task automatic test_reset_mid();
        run(7);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (out !== 4'h0 || period_start !== 1'b0) begin
                errors++; $display("FAIL midrst_c%0d got out=%h ps=%b want 0/0", c, out, period_start); end
        end
        rst = 1'b0;
        clear_counts();
        do_write(0, 5); run(PER - 1);
        checks++; if (ps_first != PER || hi_cnt[0] != 0) begin
            errors++; $display("FAIL midrst_restart got ps_at=%0d high=%0d want %0d/0", ps_first, hi_cnt[0], PER); end
        clear_counts(); run(PER);
        checks++; if (hi_cnt[0] != 5) begin errors++; $display("FAIL midrst_duty got %0d want 5", hi_cnt[0]); end
    endtask

    task automatic test_center();
        bit ok;
        prescale = 0; ch_ena = 4'hF; ena = 1'b1;
        do_write(0, 4); do_write(1, 0); do_write(2, 15);
        wait_ps(80, ok);
        checks++; if (!ok) begin errors++; $display("FAIL center_ps_timeout got 0 want 1"); end
        for (int p = 0; p < 2; p++) begin
            clear_counts(); run(PER);
            checks++; if (hi_cnt[0] != 7) begin errors++; $display("FAIL center_ch0 got %0d want 7", hi_cnt[0]); end
            checks++; if (hi_cnt[1] != 0 || hi_cnt[2] != PER) begin
                errors++; $display("FAIL center_limits got %0d/%0d want 0/%0d", hi_cnt[1], hi_cnt[2], PER); end
            checks++; if (ps_n != 1 || ps_first != 28) begin
                errors++; $display("FAIL center_period got n=%0d at=%0d want n=1 at=28", ps_n, ps_first); end
        end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        ena = 1'b1; ch_ena = 4'hF;
        for (int c = 0; c < 1200; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 99) < 2) ena = ~ena;
            if (rst || !ena) prescale = PW'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) ch_ena = CH'($urandom);
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_ch   = 2'($urandom);
            wr_duty = N'($urandom);
            tick();
            checks++;
            if (out !== m_out || period_start !== m_ps) begin
                errors++;
                if (bad < 10) $display("FAIL random_c%0d got out=%h ps=%b want out=%h ps=%b",
                                       c, out, period_start, m_out, m_ps);
                bad++;
            end
        end
        rst = 1'b0; wr_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_counts();
        test_reset();
`ifdef PWM_CENTER_ALIGNED_EN
        test_center();
`else
        test_duty_basic();
        test_prescale_write();
        test_enable();
        test_reset_mid();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
